// File: rtl/msx_bus_drive_ctrl.sv
// Purpose : sequences one drive of the MSX data bus through a 74368 inverting
//           tri-state bank: latches ~din, then runs noe through setup/drive/gap.
// Latency : noe falls SETUP_CYC edges after accept and stays low HOLD_CYC cycles.
//           done pulses GAP_CYC edges after noe rises. All outputs are registered.
// Backpressure: busy is high from accept to the end of the gap. req seen while
//           busy is dropped, with no queueing. Resubmit after done.
//
// Ports:
//   clk   - clock; every state change happens on the rising edge
//   rst   - synchronous reset, active high; it wins over all other inputs
//   req   - drive request; sampled only while busy is low
//   din   - true-polarity data word; captured inverted into a at accept
//   abort - present only when BUS_DRIVE_ABORT_EN is defined
//   noe   - active-low output enable to the 74368 bank
//   a     - buffer inputs (~din captured at accept), held until the next accept
//   busy  - high from accept until the end of the turnaround gap
//   done  - single-cycle pulse on the edge where busy returns low
//
// Optional feature: define BUS_DRIVE_ABORT_EN to add the abort input. When
// abort is high in SETUP or DRIVE, noe releases at the next edge and the
// sequence jumps to a full-length GAP. abort is ignored in IDLE and GAP.

module msx_bus_drive_ctrl #(
    parameter int WIDTH     = 8,
    parameter int SETUP_CYC = 1,
    parameter int HOLD_CYC  = 2,
    parameter int GAP_CYC   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req,
    input  logic [WIDTH-1:0] din,
`ifdef BUS_DRIVE_ABORT_EN
    input  logic             abort,
`endif
    output logic             noe,
    output logic [WIDTH-1:0] a,
    output logic             busy,
    output logic             done
);

    // Elaboration-time range checks; the counter is only 4 bits wide.
    if (SETUP_CYC < 0 || SETUP_CYC > 15) begin : g_bad_setup
        $error("msx_bus_drive_ctrl: SETUP_CYC out of range 0..15");
    end
    if (HOLD_CYC < 1 || HOLD_CYC > 15) begin : g_bad_hold
        $error("msx_bus_drive_ctrl: HOLD_CYC out of range 1..15");
    end
    if (GAP_CYC < 0 || GAP_CYC > 15) begin : g_bad_gap
        $error("msx_bus_drive_ctrl: GAP_CYC out of range 0..15");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        DRIVE = 2'd2,
        GAP   = 2'd3
    } state_t;

    // The counter is loaded with (cycles - 1) on state entry. The state is
    // left on the edge where the counter reads zero. Zero-length phases
    // never load their own count, so the clamp to zero only keeps the
    // constant in range.
    localparam logic [3:0] SETUP_LD = (SETUP_CYC > 0) ? 4'(SETUP_CYC - 1) : 4'd0;
    localparam logic [3:0] HOLD_LD  = (HOLD_CYC  > 0) ? 4'(HOLD_CYC  - 1) : 4'd0;
    localparam logic [3:0] GAP_LD   = (GAP_CYC   > 0) ? 4'(GAP_CYC   - 1) : 4'd0;

    state_t     state;
    logic [3:0] cnt;
    logic       abort_i;

`ifdef BUS_DRIVE_ABORT_EN
    assign abort_i = abort;
`else
    assign abort_i = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            // The bus is released on the very next edge, whatever the phase.
            state <= IDLE;
            cnt   <= 4'd0;
            noe   <= 1'b1;
            a     <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (req) begin
                        a    <= ~din;
                        busy <= 1'b1;
                        if (SETUP_CYC == 0) begin
                            // No setup phase: the enable drops on the accept edge.
                            noe   <= 1'b0;
                            state <= DRIVE;
                            cnt   <= HOLD_LD;
                        end else begin
                            state <= SETUP;
                            cnt   <= SETUP_LD;
                        end
                    end
                end

                SETUP: begin
                    if (abort_i) begin
                        // Abort before the bus was driven: noe simply stays high.
                        noe <= 1'b1;
                        if (GAP_CYC == 0) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= IDLE;
                            cnt   <= 4'd0;
                        end else begin
                            state <= GAP;
                            cnt   <= GAP_LD;
                        end
                    end else if (cnt == 4'd0) begin
                        noe   <= 1'b0;
                        state <= DRIVE;
                        cnt   <= HOLD_LD;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end

                DRIVE: begin
                    // Abort and normal completion share the same exit path.
                    if (abort_i || cnt == 4'd0) begin
                        noe <= 1'b1;
                        if (GAP_CYC == 0) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= IDLE;
                            cnt   <= 4'd0;
                        end else begin
                            state <= GAP;
                            cnt   <= GAP_LD;
                        end
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end

                GAP: begin
                    // Turnaround: the bank stays disabled so another driver can take the bus.
                    if (cnt == 4'd0) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= IDLE;
                        cnt   <= 4'd0;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end

                default: begin
                    state <= IDLE;
                    cnt   <= 4'd0;
                    noe   <= 1'b1;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_msx_bus_drive_ctrl.sv
// Bench for msx_bus_drive_ctrl: two instances with shared stimulus.
// Instance 0 uses the default timing. Instance 1 uses SETUP=0, HOLD=2, GAP=0.
// A timestamp model predicts every output after every edge.

module tb_msx_bus_drive_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic         req;
    logic [W-1:0] din;
`ifdef BUS_DRIVE_ABORT_EN
    logic         abort;
`endif

    logic         noe0, busy0, done0;
    logic [W-1:0] a0;
    logic         noe1, busy1, done1;
    logic [W-1:0] a1;

    msx_bus_drive_ctrl #(.WIDTH(W), .SETUP_CYC(1), .HOLD_CYC(2), .GAP_CYC(1)) dut0 (
        .clk  (clk),
        .rst  (rst),
        .req  (req),
        .din  (din),
`ifdef BUS_DRIVE_ABORT_EN
        .abort(abort),
`endif
        .noe  (noe0),
        .a    (a0),
        .busy (busy0),
        .done (done0)
    );

    msx_bus_drive_ctrl #(.WIDTH(W), .SETUP_CYC(0), .HOLD_CYC(2), .GAP_CYC(0)) dut1 (
        .clk  (clk),
        .rst  (rst),
        .req  (req),
        .din  (din),
`ifdef BUS_DRIVE_ABORT_EN
        .abort(abort),
`endif
        .noe  (noe1),
        .a    (a1),
        .busy (busy1),
        .done (done1)
    );

    // Per-instance timing parameters.
    int sc[2];
    int hc[2];
    int gc[2];

    // Model: per instance, the edge numbers where noe falls, noe rises and done fires.
    bit           act[2];
    int           tf[2];
    int           tr[2];
    int           td[2];
    logic [W-1:0] ea[2];
    logic         en[2];
    logic         eb[2];
    logic         ed[2];
    int           n;

    int total;
    int passed;
    int fails;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s at edge %0d: observed %h expected %h", tag, n, obs, exp);
        end
    endtask

    // Advance one edge, update the model from the inputs the DUT sampled, then check.
    task automatic step();
        @(posedge clk);
        n++;
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                act[i] = 1'b0;
                ea[i]  = '0;
            end else if (!act[i]) begin
                if (req) begin
                    act[i] = 1'b1;
                    tf[i]  = n + sc[i];
                    tr[i]  = tf[i] + hc[i];
                    td[i]  = tr[i] + gc[i];
                    ea[i]  = ~din;
                end
            end
`ifdef BUS_DRIVE_ABORT_EN
            else if (abort && n <= tr[i]) begin
                // Still in SETUP or DRIVE before this edge: release now, full gap follows.
                if (tf[i] > n) tf[i] = n;
                tr[i] = n;
                td[i] = n + gc[i];
            end
`endif
            en[i] = 1'b1;
            eb[i] = 1'b0;
            ed[i] = 1'b0;
            if (act[i]) begin
                en[i] = !(n >= tf[i] && n < tr[i]);
                eb[i] = (n < td[i]);
                ed[i] = (n == td[i]);
                if (n == td[i]) act[i] = 1'b0;
            end
        end
        #1;
        chk("noe0",  {7'd0, noe0},  {7'd0, en[0]});
        chk("busy0", {7'd0, busy0}, {7'd0, eb[0]});
        chk("done0", {7'd0, done0}, {7'd0, ed[0]});
        chk("a0",    a0,            ea[0]);
        chk("noe1",  {7'd0, noe1},  {7'd0, en[1]});
        chk("busy1", {7'd0, busy1}, {7'd0, eb[1]});
        chk("done1", {7'd0, done1}, {7'd0, ed[1]});
        chk("a1",    a1,            ea[1]);
    endtask

    initial begin
        total  = 0;
        passed = 0;
        fails  = 0;
        n      = 0;
        sc[0] = 1; hc[0] = 2; gc[0] = 1;
        sc[1] = 0; hc[1] = 2; gc[1] = 0;
        for (int i = 0; i < 2; i++) begin
            act[i] = 1'b0;
            tf[i] = 0; tr[i] = 0; td[i] = 0;
            ea[i] = '0;
        end
`ifdef BUS_DRIVE_ABORT_EN
        abort = 1'b0;
`endif

        // Reset held for two edges with req high: everything stays idle.
        rst = 1'b1; req = 1'b1; din = 8'hFF;
        step();
        step();
        chk("rst_noe0_const", {7'd0, noe0}, 8'd1);
        chk("rst_a0_const", a0, 8'h00);

        // Single request with din=A5, then a second request at edge 2 that must be ignored.
        rst = 1'b0; req = 1'b1; din = 8'hA5;
        step();                                 // edge 0: accept
        chk("acc_a0_const", a0, 8'h5A);
        req = 1'b0; din = 8'h00;
        step();                                 // edge 1: noe falls
        chk("setup_noe0_const", {7'd0, noe0}, 8'd0);
        req = 1'b1; din = 8'h3C;
        step();                                 // edge 2: ignored request
        req = 1'b0;
        step();                                 // edge 3: noe rises
        chk("rise_noe0_const", {7'd0, noe0}, 8'd1);
        step();                                 // edge 4: done
        chk("done0_const", {7'd0, done0}, 8'd1);
        step();                                 // edge 5: done clears
        chk("hold_a0_const", a0, 8'h5A);

        // req held high: back-to-back accepts.
        req = 1'b1;
        for (int k = 0; k < 14; k++) begin
            din = 8'($urandom);
            step();
        end
        req = 1'b0;
        for (int k = 0; k < 6; k++) step();

        // Reset one cycle after noe falls on instance 0.
        req = 1'b1; din = 8'h81;
        step();                                 // accept
        req = 1'b0;
        step();                                 // noe0 falls
        rst = 1'b1;
        step();                                 // bus released, no done
        rst = 1'b0;
        step();
        step();

`ifdef BUS_DRIVE_ABORT_EN
        // Abort in the first drive cycle of instance 0.
        req = 1'b1; din = 8'h77;
        step();                                 // accept
        req = 1'b0;
        step();                                 // noe0 falls
        abort = 1'b1;
        step();                                 // noe0 rises
        abort = 1'b0;
        step();                                 // done after the gap
        step();
        step();
`endif

        // Randomised traffic.
        for (int k = 0; k < 800; k++) begin
            rst = ($urandom_range(0, 59) == 0);
            req = ($urandom_range(0, 2) != 0);
            din = 8'($urandom);
`ifdef BUS_DRIVE_ABORT_EN
            abort = ($urandom_range(0, 7) == 0);
`endif
            step();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
